cmp_result_tracker: RTL and testbench
=====================================

// Module: cmp_result_tracker
// PURPOSE
//  - Downstream stage of the 2-bit magnitude comparator. Samples its one-hot result (AeqB/AgtB/AltB)
//    when in_valid is high and keeps saturating per-outcome event counts.
//  - Tracks a run of consecutive "equal" results and raises match once the run reaches STREAK_N.
//  - Presents a registered summary (last result code, counts, streak) to the next stage, with a
//    one-cycle out_valid pulse.
// PARAMETERS
//  - CNT_W     8  width of eq_cnt/gt_cnt/lt_cnt/streak_cnt; all counters saturate at 2**CNT_W-1
//  - STREAK_N  3  consecutive eq samples needed to enter MATCH; legal range 1..2**CNT_W-1
// PORTS
//  - clk         in   1      single clock, all state updates on rising edge
//  - rst         in   1      synchronous, active-high reset
//  - clear       in   1      synchronous soft clear; same effect as rst
//  - in_valid    in   1      comparator result valid this cycle
//  - in_eq       in   1      AeqB from comparator
//  - in_gt       in   1      AgtB from comparator
//  - in_lt       in   1      AltB from comparator
//  - out_valid   out  1      1-cycle pulse: outputs updated by an accepted sample
//  - last_code   out  2      00 none, 01 lt, 10 gt, 11 eq (most recently accepted result)
//  - eq_cnt      out  CNT_W  accepted eq results
//  - gt_cnt      out  CNT_W  accepted gt results
//  - lt_cnt      out  CNT_W  accepted lt results
//  - streak_cnt  out  CNT_W  current run of consecutive eq results
//  - match       out  1      high while in MATCH state
//  - err         out  1      sticky one-hot violation flag (tied 0 without CMP_ONEHOT_CHECK_EN)
// BEHAVIOUR
//  - Reset/clear: state=IDLE, all counts 0, last_code=00, out_valid=0, match=0, err=0.
//  - clear is identical to rst; same-cycle clear and in_valid: clear wins, sample dropped.
//  - Accept: in_valid=1 and at least one of eq/gt/lt high. All-zero result with in_valid is
//    dropped: no update, out_valid=0.
//  - Latency: sample accepted at edge N -> outputs and out_valid visible after edge N
//    (1 cycle). Back-to-back samples are accepted every cycle; no backpressure.
//  - Multi-hot (no macro): priority eq > gt > lt, i.e. the sample is treated as eq if in_eq,
//    else gt, else lt.
//  - Counters: increment by 1 on the matching outcome, hold at all-ones (no wrap).
//  - streak_cnt: +1 (saturating) on eq; cleared to 0 on gt/lt.
//  - FSM states: IDLE, TRACK, MATCH, ERR.
//    - IDLE -> TRACK on first accepted sample; -> MATCH instead if eq and STREAK_N==1.
//    - TRACK -> MATCH when the updated streak_cnt >= STREAK_N.
//    - MATCH -> TRACK on an accepted gt/lt; stays in MATCH on eq (streak saturation keeps MATCH).
//    - ERR exits only by rst/clear.
//  - match = (state==MATCH), registered, changes in the same cycle as out_valid.
// CONFIGURATION
//  - Macro CMP_ONEHOT_CHECK_EN defined:
//    - in_valid with more than one of eq/gt/lt high -> state=ERR, err=1 next cycle, out_valid=0.
//    - Counts, streak and last_code freeze; all further samples ignored until rst/clear.
//  - Macro undefined: no ERR state is reachable, err tied 0, multi-hot resolved by priority.
// STRUCTURE
//  - Shared header cmp_defs.vh: state encodings (IDLE=2'd0, TRACK=2'd1, MATCH=2'd2, ERR=2'd3)
//    and result codes (CODE_NONE/LT/GT/EQ). The header is also used by the comparator bench.
//  - Sub-module sat_counter (param W; ports clk, rst, clr, inc, q), instantiated 4x
//    (eq, gt, lt, streak). Streak uses clr on gt/lt.
// TESTING
//  - Reset: after rst, all outputs 0 and last_code=00; then a single eq sample ->
//    eq_cnt=1, streak=1, last_code=11, out_valid pulses 1 cycle.
//  - Streak: eq,eq,eq (STREAK_N=3) -> match rises after 3rd sample; a following lt ->
//    match=0, streak=0, lt_cnt=1.
//  - Saturation (CNT_W=2): 5 consecutive gt -> gt_cnt stays 3; streak stays 0.
//  - Simultaneous clear+in_valid(eq) after 2 eq samples -> all counts 0, out_valid=0, state IDLE.
//  - Invalid inputs: in_valid with all-zero -> no change. in_valid=0 with eq=1 -> no change.
//  - Multi-hot eq+gt: without macro counted as eq. With CMP_ONEHOT_CHECK_EN, err=1 and counts
//    frozen until clear.

Source files
------------

// File: rtl/cmp_result_tracker_pkg.sv
// Shared encodings for the comparator result tracker: FSM states, result codes
// and the priority helper that maps a comparator result onto a code.
package cmp_result_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        MATCH = 2'd2,
        ERR   = 2'd3
    } trkState_e;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_LT   = 2'b01;
    localparam logic [1:0] CODE_GT   = 2'b10;
    localparam logic [1:0] CODE_EQ   = 2'b11;

    // Multi-hot results resolve eq > gt > lt
    function automatic logic [1:0] resultCode(input logic eq, input logic gt, input logic lt);
        if (eq)      return CODE_EQ;
        else if (gt) return CODE_GT;
        else if (lt) return CODE_LT;
        else         return CODE_NONE;
    endfunction

endpackage

// File: rtl/cmp_result_tracker_sat_counter.sv
// Saturating up-counter with synchronous reset and a synchronous clear that
// overrides increment; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cmp_result_tracker.sv
// Tracks accepted 2-bit comparator results: saturating outcome counts, eq streak
// and MATCH detection. Optional CMP_ONEHOT_CHECK_EN traps multi-hot results in ERR.
module cmp_result_tracker
    import cmp_result_tracker_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int STREAK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_eq,
    input  logic             in_gt,
    input  logic             in_lt,
    output logic             out_valid,
    output logic [1:0]       last_code,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] streak_cnt,
    output logic             match,
    output logic             err
);

    localparam logic [CNT_W-1:0] STREAK_TGT = CNT_W'(STREAK_N);

    trkState_e        state;
    trkState_e        nextState;
    logic             softRst;
    logic             multiHot;
    logic             frozen;
    logic             accept;
    logic             isEq;
    logic             isGt;
    logic             isLt;
    logic [CNT_W-1:0] streakNext;

    assign softRst = rst | clear;

`ifdef CMP_ONEHOT_CHECK_EN
    logic errQ;
    assign multiHot = (in_eq & in_gt) | (in_eq & in_lt) | (in_gt & in_lt);
    assign frozen   = (state == ERR);
    assign err      = errQ;
`else
    assign multiHot = 1'b0;
    assign frozen   = 1'b0;
    assign err      = 1'b0;
`endif

    assign accept = in_valid & (in_eq | in_gt | in_lt) & ~multiHot & ~frozen;
    assign isEq   = in_eq;
    assign isGt   = ~in_eq & in_gt;
    assign isLt   = ~in_eq & ~in_gt & in_lt;

    // FSM decides on the streak value the counter will hold after this edge
    assign streakNext = !isEq ? '0 :
                        (streak_cnt == '1) ? streak_cnt : streak_cnt + CNT_W'(1);
    assign nextState  = (isEq && (streakNext >= STREAK_TGT)) ? MATCH : TRACK;

    sat_counter #(.W(CNT_W)) uEqCnt (
        .clk(clk), .rst(softRst), .clr(1'b0), .inc(accept & isEq), .q(eq_cnt)
    );
    sat_counter #(.W(CNT_W)) uGtCnt (
        .clk(clk), .rst(softRst), .clr(1'b0), .inc(accept & isGt), .q(gt_cnt)
    );
    sat_counter #(.W(CNT_W)) uLtCnt (
        .clk(clk), .rst(softRst), .clr(1'b0), .inc(accept & isLt), .q(lt_cnt)
    );
    sat_counter #(.W(CNT_W)) uStreakCnt (
        .clk(clk), .rst(softRst), .clr(accept & ~isEq), .inc(accept & isEq), .q(streak_cnt)
    );

    always_ff @(posedge clk) begin
        if (softRst) begin
            state     <= IDLE;
            last_code <= CODE_NONE;
            out_valid <= 1'b0;
            match     <= 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
            errQ      <= 1'b0;
`endif
        end else begin
            out_valid <= accept;
`ifdef CMP_ONEHOT_CHECK_EN
            if (in_valid && multiHot && !frozen) begin
                state <= ERR;
                match <= 1'b0;
                errQ  <= 1'b1;
            end
`endif
            if (accept) begin
                state     <= nextState;
                match     <= (nextState == MATCH);
                last_code <= resultCode(in_eq, in_gt, in_lt);
            end
        end
    end

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed bench for cmp_result_tracker (CNT_W=2, STREAK_N=3); expectations follow
// CMP_ONEHOT_CHECK_EN when the macro is defined for the build.
module tb_cmp_result_tracker;

    localparam int CNT_W    = 2;
    localparam int STREAK_N = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_eq = 1'b0;
    logic             in_gt = 1'b0;
    logic             in_lt = 1'b0;
    logic             out_valid;
    logic [1:0]       last_code;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] streak_cnt;
    logic             match;
    logic             err;

    int nChecks = 0;
    int nFails  = 0;

    cmp_result_tracker #(.CNT_W(CNT_W), .STREAK_N(STREAK_N)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_eq(in_eq), .in_gt(in_gt), .in_lt(in_lt),
        .out_valid(out_valid), .last_code(last_code),
        .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
        .streak_cnt(streak_cnt), .match(match), .err(err)
    );

    always #5 clk = ~clk;

    // Observed bundle: {out_valid, last_code, eq, gt, lt, streak, match, err}
    function automatic logic [12:0] snap();
        return {out_valid, last_code, eq_cnt, gt_cnt, lt_cnt, streak_cnt, match, err};
    endfunction

    function automatic logic [12:0] exp(input logic ov, input logic [1:0] lc, input int e,
                                        input int g, input int l, input int s,
                                        input logic m, input logic er);
        return {ov, lc, 2'(e), 2'(g), 2'(l), 2'(s), m, er};
    endfunction

    // Inputs change on the falling edge, outputs are read 1 ns after the rising edge
    task automatic drive(input logic v, input logic c, input logic eq, input logic gt,
                         input logic lt);
        @(negedge clk);
        in_valid = v; clear = c; in_eq = eq; in_gt = gt; in_lt = lt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] want;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if (snap() !== 13'd0) begin
            nFails++;
            $display("FAIL reset_state got %h want %h", snap(), 13'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 1, 0, 0);
        want = exp(1, 2'b11, 1, 0, 0, 1, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL reset_first_eq got %h want %h", snap(), want);
        end
        drive(0, 0, 0, 0, 0);
        want = exp(0, 2'b11, 1, 0, 0, 1, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL reset_pulse_end got %h want %h", snap(), want);
        end
    endtask

    task automatic test_streak();
        logic [12:0] want;
        drive(0, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 1, 0, 0);
            want = exp(1, 2'b11, i, 0, 0, i, (i >= STREAK_N), 0);
            nChecks++;
            if (snap() !== want) begin
                nFails++;
                $display("FAIL streak_eq%0d got %h want %h", i, snap(), want);
            end
        end
        drive(1, 0, 0, 0, 1);
        want = exp(1, 2'b01, 3, 0, 1, 0, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL streak_break_lt got %h want %h", snap(), want);
        end
    endtask

    task automatic test_saturation();
        logic [12:0] want;
        drive(0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 1, 0);
            want = exp(1, 2'b10, 0, (i > 3) ? 3 : i, 0, 0, 0, 0);
            nChecks++;
            if (snap() !== want) begin
                nFails++;
                $display("FAIL sat_gt%0d got %h want %h", i, snap(), want);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 1, 0, 0);
            want = exp(1, 2'b11, (i > 3) ? 3 : i, 3, 0, (i > 3) ? 3 : i, (i >= 3), 0);
            nChecks++;
            if (snap() !== want) begin
                nFails++;
                $display("FAIL sat_eq%0d got %h want %h", i, snap(), want);
            end
        end
    endtask

    task automatic test_clear_wins();
        logic [12:0] want;
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        want = exp(1, 2'b11, 2, 0, 0, 2, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL clr_pre got %h want %h", snap(), want);
        end
        drive(1, 1, 1, 0, 0);
        nChecks++;
        if (snap() !== 13'd0) begin
            nFails++;
            $display("FAIL clr_wins got %h want %h", snap(), 13'd0);
        end
        drive(1, 0, 1, 0, 0);
        want = exp(1, 2'b11, 1, 0, 0, 1, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL clr_restart got %h want %h", snap(), want);
        end
    endtask

    task automatic test_invalid();
        logic [12:0] want;
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        want = exp(0, 2'b01, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL inv_allzero got %h want %h", snap(), want);
        end
        drive(0, 0, 1, 0, 0);
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL inv_novalid got %h want %h", snap(), want);
        end
    endtask

    task automatic test_multihot();
        logic [12:0] want;
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0);
`ifdef CMP_ONEHOT_CHECK_EN
        want = exp(0, 2'b00, 0, 0, 0, 0, 0, 1);
`else
        want = exp(1, 2'b11, 1, 0, 0, 1, 0, 0);
`endif
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL mh_eqgt got %h want %h", snap(), want);
        end
        drive(1, 0, 0, 1, 0);
`ifdef CMP_ONEHOT_CHECK_EN
        want = exp(0, 2'b00, 0, 0, 0, 0, 0, 1);
`else
        want = exp(1, 2'b10, 1, 1, 0, 0, 0, 0);
`endif
        nChecks++;
        if (snap() !== want) begin
            nFails++;
            $display("FAIL mh_follow_gt got %h want %h", snap(), want);
        end
        drive(0, 1, 0, 0, 0);
        nChecks++;
        if (snap() !== 13'd0) begin
            nFails++;
            $display("FAIL mh_clear got %h want %h", snap(), 13'd0);
        end
    endtask

    initial begin
        test_reset();
        test_streak();
        test_saturation();
        test_clear_wins();
        test_invalid();
        test_multihot();
        drive(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
